// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with a refill FSM
// in front of a multi-cycle backing memory. Read hits answer combinationally;
// read misses and all stores stall the pipeline until the memory acks.
module dcache_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SET_BITS      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt
);

  localparam int unsigned NUM_SETS = 1 << SET_BITS;
  localparam int          TAG_BITS = ADDRESS_WIDTH - SET_BITS - 2;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  state_t state;

  logic                  validArr [NUM_SETS];
  logic [TAG_BITS-1:0]   tagArr   [NUM_SETS];
  logic [DATA_WIDTH-1:0] dataArr  [NUM_SETS];

  logic [SET_BITS-1:0] cpuSet;
  logic [TAG_BITS-1:0] cpuTag;
  logic                cpuHit;
  logic [SET_BITS-1:0] memSet;
  logic [TAG_BITS-1:0] memTag;
  logic                memHit;
  logic                ackValid;

  // Set/tag decode for the live CPU address and for the latched request address
  always_comb begin
    cpuSet   = cpu_addr[SET_BITS+1:2];
    cpuTag   = cpu_addr[ADDRESS_WIDTH-1:SET_BITS+2];
    cpuHit   = validArr[cpuSet] && (tagArr[cpuSet] == cpuTag);
    memSet   = mem_addr[SET_BITS+1:2];
    memTag   = mem_addr[ADDRESS_WIDTH-1:SET_BITS+2];
    memHit   = validArr[memSet] && (tagArr[memSet] == memTag);
    ackValid = (state != IDLE) && mem_ack;
  end

  // Load data: refill data is bypassed in the ack cycle, otherwise the array word
  always_comb begin
    cpu_rdata = dataArr[cpuSet];
    if (state == FILL && mem_ack) begin
      cpu_rdata = mem_rdata;
    end
  end

  // Pipeline freeze: request detect in IDLE, or busy without ack
  always_comb begin
    stall = 1'b0;
    if (state == IDLE) begin
      stall = cpu_we || (cpu_re && !cpuHit);
    end else begin
      stall = !mem_ack;
    end
  end

  // Controller FSM with registered memory-side outputs, line arrays and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      for (int unsigned i = 0; i < NUM_SETS; i++) begin
        validArr[i] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cpu_we) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= cpu_addr & ~ADDRESS_WIDTH'(3);
            mem_wdata <= cpu_wdata;
          end else if (cpu_re && !cpuHit) begin
            state     <= FILL;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= cpu_addr & ~ADDRESS_WIDTH'(3);
            mem_wdata <= cpu_wdata;
            miss_cnt  <= miss_cnt + 32'd1;
          end else if (cpu_re) begin
            hit_cnt <= hit_cnt + 32'd1;
          end
        end
        FILL: begin
          if (ackValid) begin
            validArr[memSet] <= 1'b1;
            tagArr[memSet]   <= memTag;
            dataArr[memSet]  <= mem_rdata;
            mem_req          <= 1'b0;
            state            <= IDLE;
          end
        end
        WRITE: begin
          if (ackValid) begin
            // write-through: only refresh a resident line, never allocate
            if (memHit) begin
              dataArr[memSet] <= mem_wdata;
            end
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed, table-driven bench for dcache_ctrl with a responding backing memory.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_re;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int nChecks = 0;
  int nFails  = 0;

  dcache_ctrl #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .SET_BITS     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_re   (cpu_re),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          waits;
    int          expStalls;
    logic        chkRd;
    logic [31:0] expRd;
    logic        expReq;
    logic        expWe;
    logic [31:0] expAddr;
    logic [31:0] expHit;
    logic [31:0] expMiss;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One CPU access; the memory acks after 'waits' cycles of mem_req
  task automatic access(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mdata, input int waits,
                        output int stalls, output logic [31:0] rd, output logic reqSeen,
                        output logic weSeen, output logic [31:0] addrSeen,
                        output logic [31:0] wdataSeen, output logic unstable,
                        output logic timedOut);
    int  reqCycles;
    logic done;
    cpu_re    = re;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    mem_ack   = 1'b0;
    stalls    = 0;
    rd        = '0;
    reqSeen   = 1'b0;
    weSeen    = 1'b0;
    addrSeen  = '0;
    wdataSeen = '0;
    unstable  = 1'b0;
    timedOut  = 1'b0;
    reqCycles = 0;
    done      = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (mem_req) begin
        if (reqSeen && (mem_we !== weSeen || mem_addr !== addrSeen || mem_wdata !== wdataSeen))
          unstable = 1'b1;
        reqSeen   = 1'b1;
        weSeen    = mem_we;
        addrSeen  = mem_addr;
        wdataSeen = mem_wdata;
        if (reqCycles == waits) begin
          mem_ack   = 1'b1;
          mem_rdata = mdata;
        end
        reqCycles++;
      end
      #1;
      if (stall) stalls++;
      else begin
        rd   = cpu_rdata;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      if (done) break;
    end
    if (!done) timedOut = 1'b1;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
  endtask

  int          stalls;
  logic [31:0] rd;
  logic        reqSeen;
  logic        weSeen;
  logic [31:0] addrSeen;
  logic [31:0] wdataSeen;
  logic        unstable;
  logic        timedOut;

  initial begin
    //          re    we    addr         wdata         mdata         w  st chk  expRd         req   we    expAddr      hit    miss
    vecs[0]  = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 2, 3, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h10, 32'd0, 32'd1};
    vecs[1]  = '{1'b1, 1'b0, 32'h10, 32'h0,        32'h0,        0, 0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,  32'd1, 32'd1};
    vecs[2]  = '{1'b1, 1'b0, 32'h30, 32'h0,        32'h30303030, 0, 1, 1'b1, 32'h30303030, 1'b1, 1'b0, 32'h30, 32'd1, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 32'h10, 32'h0,        32'h10101010, 1, 2, 1'b1, 32'h10101010, 1'b1, 1'b0, 32'h10, 32'd1, 32'd3};
    vecs[4]  = '{1'b1, 1'b0, 32'h24, 32'h0,        32'h11111111, 1, 2, 1'b1, 32'h11111111, 1'b1, 1'b0, 32'h24, 32'd1, 32'd4};
    vecs[5]  = '{1'b0, 1'b1, 32'h24, 32'hAAAA5555, 32'h0,        2, 3, 1'b0, 32'h0,        1'b1, 1'b1, 32'h24, 32'd1, 32'd4};
    vecs[6]  = '{1'b1, 1'b0, 32'h24, 32'h0,        32'h0,        0, 0, 1'b1, 32'hAAAA5555, 1'b0, 1'b0, 32'h0,  32'd2, 32'd4};
    vecs[7]  = '{1'b0, 1'b1, 32'h40, 32'h40404040, 32'h0,        0, 1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h40, 32'd2, 32'd4};
    vecs[8]  = '{1'b1, 1'b0, 32'h40, 32'h0,        32'h44440000, 0, 1, 1'b1, 32'h44440000, 1'b1, 1'b0, 32'h40, 32'd2, 32'd5};
    vecs[9]  = '{1'b1, 1'b1, 32'h0B, 32'h0B0B0B0B, 32'h0,        1, 2, 1'b0, 32'h0,        1'b1, 1'b1, 32'h08, 32'd2, 32'd5};
    vecs[10] = '{1'b1, 1'b0, 32'h08, 32'h0,        32'h88888888, 0, 1, 1'b1, 32'h88888888, 1'b1, 1'b0, 32'h08, 32'd2, 32'd6};
    vecs[11] = '{1'b1, 1'b0, 32'h0B, 32'h0,        32'h0,        0, 0, 1'b1, 32'h88888888, 1'b0, 1'b0, 32'h0,  32'd3, 32'd6};

    rst       = 1'b1;
    cpu_re    = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset mem_req",   {31'b0, mem_req}, 32'd0);
    check("reset mem_we",    {31'b0, mem_we},  32'd0);
    check("reset mem_addr",  mem_addr,         32'h0);
    check("reset mem_wdata", mem_wdata,        32'h0);
    check("reset hit_cnt",   hit_cnt,          32'd0);
    check("reset miss_cnt",  miss_cnt,         32'd0);
    check("reset stall",     {31'b0, stall},   32'd0);

    // stray ack while idle must be ignored
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("idle ack mem_req",  {31'b0, mem_req}, 32'd0);
    check("idle ack miss_cnt", miss_cnt,         32'd0);

    for (int i = 0; i < 12; i++) begin
      access(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mdata, vecs[i].waits,
             stalls, rd, reqSeen, weSeen, addrSeen, wdataSeen, unstable, timedOut);
      check($sformatf("row%0d timeout", i), {31'b0, timedOut}, 32'd0);
      check($sformatf("row%0d stall cycles", i), stalls, vecs[i].expStalls);
      if (vecs[i].chkRd) check($sformatf("row%0d cpu_rdata", i), rd, vecs[i].expRd);
      check($sformatf("row%0d mem_req seen", i), {31'b0, reqSeen}, {31'b0, vecs[i].expReq});
      if (vecs[i].expReq) begin
        check($sformatf("row%0d mem_we", i), {31'b0, weSeen}, {31'b0, vecs[i].expWe});
        check($sformatf("row%0d mem_addr", i), addrSeen, vecs[i].expAddr);
        check($sformatf("row%0d req stable", i), {31'b0, unstable}, 32'd0);
        if (vecs[i].expWe) check($sformatf("row%0d mem_wdata", i), wdataSeen, vecs[i].wdata);
      end
      check($sformatf("row%0d mem_req after", i), {31'b0, mem_req}, 32'd0);
      check($sformatf("row%0d hit_cnt", i), hit_cnt, vecs[i].expHit);
      check($sformatf("row%0d miss_cnt", i), miss_cnt, vecs[i].expMiss);
    end

    // Reset during FILL: rst and ack land in the same wait cycle
    cpu_re   = 1'b1;
    cpu_addr = 32'h50;
    #1;
    check("rstfill detect stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    check("rstfill mem_req up", {31'b0, mem_req}, 32'd1);
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h55555555;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    cpu_re    = 1'b0;
    #1;
    check("rstfill mem_req", {31'b0, mem_req}, 32'd0);
    check("rstfill hit_cnt", hit_cnt, 32'd0);
    check("rstfill miss_cnt", miss_cnt, 32'd0);
    @(posedge clk);
    #1;
    check("rstfill still idle", {31'b0, mem_req}, 32'd0);

    access(1'b1, 1'b0, 32'h50, 32'h0, 32'h50505050, 0,
           stalls, rd, reqSeen, weSeen, addrSeen, wdataSeen, unstable, timedOut);
    check("post-rst 0x50 stalls", stalls, 32'd1);
    check("post-rst 0x50 data", rd, 32'h50505050);
    check("post-rst miss_cnt a", miss_cnt, 32'd1);

    access(1'b1, 1'b0, 32'h24, 32'h0, 32'h24242424, 1,
           stalls, rd, reqSeen, weSeen, addrSeen, wdataSeen, unstable, timedOut);
    check("post-rst 0x24 stalls", stalls, 32'd2);
    check("post-rst 0x24 data", rd, 32'h24242424);
    check("post-rst miss_cnt b", miss_cnt, 32'd2);
    check("post-rst hit_cnt", hit_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
